// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: register map,
// table geometry, FSM encoding and the table entry layout.
package pll_reconfig_pkg;

    localparam logic [5:0] ADDR_MODE  = 6'd0;
    localparam logic [5:0] ADDR_START = 6'd2;
    localparam logic [5:0] ADDR_N     = 6'd3;
    localparam logic [5:0] ADDR_M     = 6'd4;
    localparam logic [5:0] ADDR_C0    = 6'd5;
    localparam logic [5:0] ADDR_K     = 6'd7;
    localparam logic [5:0] ADDR_BW    = 6'd8;
    localparam logic [5:0] ADDR_CP    = 6'd9;

    localparam int NUM_ENTRIES = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] value;
    } pll_entry_t;

    // Write order of the table: mode reg first, start register last so the
    // PLL only relocks once every divider is in place.
    function automatic logic [5:0] entry_addr(input logic [2:0] idx);
        logic [5:0] a;
        case (idx)
            3'd0:    a = ADDR_MODE;
            3'd1:    a = ADDR_N;
            3'd2:    a = ADDR_M;
            3'd3:    a = ADDR_C0;
            3'd4:    a = ADDR_K;
            3'd5:    a = ADDR_BW;
            3'd6:    a = ADDR_CP;
            default: a = ADDR_START;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/pll_mode_rom.sv
// Per-mode PLL reconfiguration table, read synchronously with one cycle of
// latency. Modes at or above NUM_MODES read back as all-zero data.
module pll_mode_rom
    import pll_reconfig_pkg::*;
#(
    parameter int NUM_MODES = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rd_en,
    input  logic [2:0]  mode,
    input  logic [2:0]  idx,
    output logic [5:0]  addr,
    output logic [31:0] value
);

    localparam logic [3:0] NUM_MODES_L = 4'(NUM_MODES);

    pll_entry_t  entry_q, entry_d;
    logic [31:0] n_v, m_v, c0_v, k_v, bw_v, cp_v;
    logic        mode_ok;

    assign mode_ok = ({1'b0, mode} < NUM_MODES_L);

    // Table contents and read-port next value.
    always_comb begin
        n_v  = '0;
        m_v  = '0;
        c0_v = '0;
        k_v  = '0;
        bw_v = '0;
        cp_v = '0;
        case (mode)
            3'd0: begin
                n_v = 32'h0000_0404; m_v = 32'h0000_1E1E; c0_v = 32'h0000_2020;
                k_v = 32'h0000_0000; bw_v = 32'h0000_0006; cp_v = 32'h0000_0002;
            end
            3'd1: begin
                n_v = 32'h0000_0202; m_v = 32'h0000_2222; c0_v = 32'h0000_1212;
                k_v = 32'h8000_0000; bw_v = 32'h0000_0007; cp_v = 32'h0000_0002;
            end
            3'd2: begin
                n_v = 32'h0000_0303; m_v = 32'h0000_3837; c0_v = 32'h0000_0909;
                k_v = 32'h4CCC_CCCD; bw_v = 32'h0000_0006; cp_v = 32'h0000_0003;
            end
            3'd3: begin
                n_v = 32'h0000_0101; m_v = 32'h0000_0F0F; c0_v = 32'h0000_0505;
                k_v = 32'h147A_E148; bw_v = 32'h0000_0008; cp_v = 32'h0000_0001;
            end
            3'd4: begin
                n_v = 32'h0000_0101; m_v = 32'h0000_1414; c0_v = 32'h0000_0202;
                k_v = 32'h0000_0000; bw_v = 32'h0000_0006; cp_v = 32'h0000_0001;
            end
            default: ;
        endcase

        entry_d = entry_q;
        if (rd_en) begin
            entry_d.addr  = entry_addr(idx);
            entry_d.value = '0;
            if (mode_ok) begin
                case (idx)
                    3'd1:    entry_d.value = n_v;
                    3'd2:    entry_d.value = m_v;
                    3'd3:    entry_d.value = c0_v;
                    3'd4:    entry_d.value = k_v;
                    3'd5:    entry_d.value = bw_v;
                    3'd6:    entry_d.value = cp_v;
                    default: entry_d.value = '0;
                endcase
            end
        end
    end

    // Registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) entry_q <= '0;
        else          entry_q <= entry_d;
    end

    assign addr  = entry_q.addr;
    assign value = entry_q.value;

endmodule

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: streams the 8-entry table of a requested
// mode into the reconfig FIFO, waits for the PLL to settle, then releases
// the video timing generator.
//
//   state  | meaning
//   IDLE   | waiting for a request (fresh or pending)
//   LOAD   | ROM read of {mode, index} in flight
//   WRITE  | entry presented to the FIFO, waiting for a non-full cycle
//   SETTLE | all entries written, counting down the lock time
//   DONE   | sequence complete, status updated on the next cycle
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int NUM_MODES     = 5,
    parameter int SETTLE_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mode_req,
    input  logic [2:0]  mode_sel,
    input  logic        pll_busy,
    output logic [5:0]  pll_addr,
    output logic [31:0] pll_value,
    output logic        pll_write,
    output logic        seq_busy,
    output logic        video_hold,
    output logic        seq_done,
    output logic [2:0]  cur_mode,
    output logic        mode_err
);

    localparam logic [3:0] NUM_MODES_L = 4'(NUM_MODES);
    localparam int         CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [2:0] LAST_IDX    = 3'(NUM_ENTRIES - 1);

    state_t           state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_vld_q, pend_vld_d;
    logic [2:0]       pend_mode_q, pend_mode_d;
    logic             seq_busy_q, seq_busy_d;
    logic             video_hold_q, video_hold_d;
    logic             seq_done_q, seq_done_d;
    logic [2:0]       cur_mode_q, cur_mode_d;
    logic             mode_err_q, mode_err_d;

    logic             sel_ok, req_valid, req_bad;
    logic [5:0]       rom_addr;
    logic [31:0]      rom_value;

    assign sel_ok    = ({1'b0, mode_sel} < NUM_MODES_L);
    assign req_valid = mode_req && sel_ok;
    assign req_bad   = mode_req && !sel_ok;

    pll_mode_rom #(.NUM_MODES(NUM_MODES)) u_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .rd_en   (state_q == ST_LOAD),
        .mode    (mode_q),
        .idx     (idx_q),
        .addr    (rom_addr),
        .value   (rom_value)
    );

    assign pll_write = (state_q == ST_WRITE) && !pll_busy;
    assign pll_addr  = (state_q == ST_WRITE) ? rom_addr  : '0;
    assign pll_value = (state_q == ST_WRITE) ? rom_value : '0;

    // Sequencing, pending-request capture and status next values.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_mode_d = pend_mode_q;

        case (state_q)
            ST_IDLE: begin
                // A fresh request in this cycle is newer than any pending one.
                if (req_valid) begin
                    mode_d     = mode_sel;
                    idx_d      = '0;
                    pend_vld_d = 1'b0;
                    state_d    = ST_LOAD;
                end else if (pend_vld_q) begin
                    mode_d     = pend_mode_q;
                    idx_d      = '0;
                    pend_vld_d = 1'b0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_WRITE;
            ST_WRITE: begin
                if (pll_write) begin
                    if (idx_q == LAST_IDX) begin
                        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                        state_d = ST_SETTLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) state_d = ST_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Requests arriving mid-sequence wait here; the newest one wins.
        if (req_valid && (state_q != ST_IDLE)) begin
            pend_vld_d  = 1'b1;
            pend_mode_d = mode_sel;
        end

        seq_busy_d   = (state_d != ST_IDLE);
        video_hold_d = (state_d != ST_IDLE);
        seq_done_d   = (state_q == ST_DONE);
        cur_mode_d   = (state_q == ST_DONE) ? mode_q : cur_mode_q;
        mode_err_d   = req_bad;
    end

    // State and status registers; video_hold comes out of reset asserted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            mode_q       <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            pend_vld_q   <= 1'b0;
            pend_mode_q  <= '0;
            seq_busy_q   <= 1'b0;
            video_hold_q <= 1'b1;
            seq_done_q   <= 1'b0;
            cur_mode_q   <= '0;
            mode_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pend_vld_q   <= pend_vld_d;
            pend_mode_q  <= pend_mode_d;
            seq_busy_q   <= seq_busy_d;
            video_hold_q <= video_hold_d;
            seq_done_q   <= seq_done_d;
            cur_mode_q   <= cur_mode_d;
            mode_err_q   <= mode_err_d;
        end
    end

    assign seq_busy   = seq_busy_q;
    assign video_hold = video_hold_q;
    assign seq_done   = seq_done_q;
    assign cur_mode   = cur_mode_q;
    assign mode_err   = mode_err_q;

endmodule
